// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - mode encodings shared by the scan buffer controller and its bench-facing state port
package scan_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_LOW_POWER = 3'd0;
    localparam state_t ST_ACTIVE    = 3'd1;
    localparam state_t ST_STANDBY   = 3'd2;
    localparam state_t ST_IDLE      = 3'd3;
    localparam state_t ST_FLUSH     = 3'd4;
    localparam state_t ST_TRANSFER  = 3'd5;

endpackage

// File: rtl/scan_mem.sv
// rtl/scan_mem.sv - DEPTH x DATA_W flop array, one sync write port, one async read port, per-entry sync clear
module scan_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 10,
    parameter int AW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    input  logic [AW-1:0]     caddr,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (waddr == AW'(i))) begin
                mem_q[i] <= wdata;
            end else if (clr && (caddr == AW'(i))) begin
                mem_q[i] <= '0;
            end
        end
    end

    // Pointers can sit at DEPTH after the last beat; read back zero there.
    assign rdata = (raddr < AW'(DEPTH)) ? mem_q[raddr] : '0;

endmodule

// File: rtl/scan_buffer_ctrl.sv
// rtl/scan_buffer_ctrl.sv - scanner front end: capture buffer, drain stream, power modes, peer early-warning flags
// Optional write checksum output enabled by SCAN_CKSUM_EN.
module scan_buffer_ctrl
    import scan_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 10,
    parameter int READY_MARGIN = 3,
    parameter int START_MARGIN = 2,
    localparam int FW          = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_scan,
    input  logic              go_to_standby,
    input  logic              transfer,
    input  logic              flush_req,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [FW-1:0]     fill,
    output logic [2:0]        state,
    output logic              ready_to_transfer,
    output logic              ready_second_buffer,
    output logic              start_second_buffer,
    output logic              overflow,
    output logic              done
`ifdef SCAN_CKSUM_EN
    ,
    output logic [DATA_W-1:0] cksum
`endif
);

    localparam logic [FW-1:0] FULL_FILL  = FW'(DEPTH);
    localparam logic [FW-1:0] READY_FILL = FW'(DEPTH - READY_MARGIN);
    localparam logic [FW-1:0] START_FILL = FW'(DEPTH - START_MARGIN);
    localparam logic [FW-1:0] ONE        = FW'(1);

    state_t          state_q, state_d;
    logic [FW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            rts_q, rts_d, rsb_q, rsb_d, ssb_q, ssb_d;
    logic            ovf_q, ovf_d, done_q, done_d;
    logic            wr_accept, beat, xfer_last, flush_clr;
    logic [FW-1:0]   fill_post, clr_addr;
`ifdef SCAN_CKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;
`endif

    scan_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (FW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .clr   (flush_clr),
        .caddr (clr_addr),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign wr_accept = (state_q == ST_ACTIVE) && wr_en && (wr_ptr_q < FULL_FILL);
    assign fill_post = wr_ptr_q + {{(FW-1){1'b0}}, wr_accept};
    assign rd_valid  = (state_q == ST_TRANSFER) && (rd_ptr_q < wr_ptr_q);
    assign beat      = rd_valid && rd_ready;
    assign xfer_last = (state_q == ST_TRANSFER) &&
                       (!rd_valid || (beat && ((rd_ptr_q + ONE) == wr_ptr_q)));
    assign flush_clr = (state_q == ST_FLUSH) && (wr_ptr_q != '0);
    assign clr_addr  = wr_ptr_q - ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOW_POWER;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rts_q    <= 1'b0;
            rsb_q    <= 1'b0;
            ssb_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef SCAN_CKSUM_EN
            cksum_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rts_q    <= rts_d;
            rsb_q    <= rsb_d;
            ssb_q    <= ssb_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
`ifdef SCAN_CKSUM_EN
            cksum_q  <= cksum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOW_POWER: begin
                if (start_scan && !transfer) state_d = ST_ACTIVE;
                else if (go_to_standby)      state_d = ST_STANDBY;
            end
            ST_STANDBY:  if (start_scan) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (transfer)                   state_d = ST_TRANSFER;
                else if (fill_post == FULL_FILL) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (transfer)       state_d = ST_TRANSFER;
                else if (flush_req) state_d = ST_FLUSH;
            end
            ST_FLUSH:    if (wr_ptr_q <= ONE) state_d = ST_LOW_POWER;
            ST_TRANSFER: if (xfer_last) state_d = ST_LOW_POWER;
            default:     state_d = ST_LOW_POWER;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rts_d    = rts_q;
        rsb_d    = rsb_q;
        ssb_d    = ssb_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
`ifdef SCAN_CKSUM_EN
        cksum_d  = cksum_q;
`endif
        case (state_q)
            ST_LOW_POWER: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                rts_d    = 1'b0;
                rsb_d    = 1'b0;
                ssb_d    = 1'b0;
                ovf_d    = 1'b0;
`ifdef SCAN_CKSUM_EN
                cksum_d  = '0;
`endif
            end
            ST_ACTIVE: begin
                wr_ptr_d = fill_post;
                rts_d    = fill_post >= READY_FILL;
                rsb_d    = fill_post >= READY_FILL;
                ssb_d    = fill_post >= START_FILL;
                if (wr_en && (wr_ptr_q == FULL_FILL)) ovf_d = 1'b1;
`ifdef SCAN_CKSUM_EN
                if (wr_accept) cksum_d = cksum_q ^ wr_data;
`endif
            end
            // IDLE is only reached with a full buffer, so any write here is lost.
            ST_IDLE: begin
                rts_d = 1'b1;
                rsb_d = 1'b0;
                ssb_d = 1'b0;
                if (wr_en) ovf_d = 1'b1;
            end
            ST_FLUSH: begin
                if (flush_clr) wr_ptr_d = wr_ptr_q - ONE;
            end
            ST_TRANSFER: begin
                if (beat) rd_ptr_d = rd_ptr_q + ONE;
                done_d = xfer_last;
            end
            default: ;
        endcase
    end

    assign fill                = wr_ptr_q;
    assign state               = state_q;
    assign ready_to_transfer   = rts_q;
    assign ready_second_buffer = rsb_q;
    assign start_second_buffer = ssb_q;
    assign overflow            = ovf_q;
    assign done                = done_q;
`ifdef SCAN_CKSUM_EN
    assign cksum               = cksum_q;
`endif

endmodule

// File: tb/tb_scan_buffer_ctrl.sv
// tb/tb_scan_buffer_ctrl.sv - randomized bench for scan_buffer_ctrl against a queue-based mode model
module tb_scan_buffer_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int RM    = 3;
    localparam int SM    = 2;

    logic          clk = 1'b0;
    logic          rst, start_scan, go_to_standby, transfer, flush_req, wr_en, rd_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [3:0]    fill;
    logic [2:0]    state;
    logic          ready_to_transfer, ready_second_buffer, start_second_buffer, overflow, done;
`ifdef SCAN_CKSUM_EN
    logic [DW-1:0] cksum;
`endif

    int total = 0;
    int bad   = 0;

    int            m_state;
    logic [DW-1:0] m_buf[$];
    int            m_rd;
    bit            m_rts, m_rsb, m_ssb, m_ovf, m_done;
    logic [DW-1:0] m_ck;

    always #5 clk = ~clk;

    scan_buffer_ctrl #(
        .DATA_W(DW), .DEPTH(DEPTH), .READY_MARGIN(RM), .START_MARGIN(SM)
    ) dut (
        .clk(clk), .rst(rst), .start_scan(start_scan), .go_to_standby(go_to_standby),
        .transfer(transfer), .flush_req(flush_req), .wr_en(wr_en), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .fill(fill),
        .state(state), .ready_to_transfer(ready_to_transfer),
        .ready_second_buffer(ready_second_buffer), .start_second_buffer(start_second_buffer),
        .overflow(overflow), .done(done)
`ifdef SCAN_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    task automatic model_reset();
        m_state = 0; m_buf.delete(); m_rd = 0;
        m_rts = 0; m_rsb = 0; m_ssb = 0; m_ovf = 0; m_done = 0; m_ck = '0;
    endtask

    // Next-cycle behaviour of the scanner, written in terms of a word queue.
    task automatic model_step();
        logic [DW-1:0] tmp;
        m_done = 0;
        if (rst) begin
            model_reset();
            return;
        end
        case (m_state)
            0: begin
                m_buf.delete(); m_rd = 0;
                m_rts = 0; m_rsb = 0; m_ssb = 0; m_ovf = 0; m_ck = '0;
                if (start_scan && !transfer) m_state = 1;
                else if (go_to_standby) m_state = 2;
            end
            2: if (start_scan) m_state = 1;
            1: begin
                if (wr_en) begin
                    if (m_buf.size() < DEPTH) begin
                        m_buf.push_back(wr_data);
                        m_ck = m_ck ^ wr_data;
                    end else m_ovf = 1;
                end
                m_rts = m_buf.size() >= DEPTH - RM;
                m_rsb = m_rts;
                m_ssb = m_buf.size() >= DEPTH - SM;
                if (transfer) m_state = 5;
                else if (m_buf.size() == DEPTH) m_state = 3;
            end
            3: begin
                m_rts = 1; m_rsb = 0; m_ssb = 0;
                if (wr_en) m_ovf = 1;
                if (transfer) m_state = 5;
                else if (flush_req) m_state = 4;
            end
            4: begin
                if (m_buf.size() > 0) tmp = m_buf.pop_back();
                if (m_buf.size() == 0) m_state = 0;
            end
            5: begin
                if (m_rd >= m_buf.size()) begin
                    m_done = 1; m_state = 0;
                end else if (rd_ready) begin
                    m_rd++;
                    if (m_rd == m_buf.size()) begin
                        m_done = 1; m_state = 0;
                    end
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic apply(input bit s, input bit gs, input bit t, input bit f,
                         input bit we, input logic [DW-1:0] d, input bit rr);
        start_scan = s; go_to_standby = gs; transfer = t; flush_req = f;
        wr_en = we; wr_data = d; rd_ready = rr;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit exp_valid();
        return (m_state == 5) && (m_rd < m_buf.size());
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 8'h00, 0);
        tick();
        tick();
        rst = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (fill !== 4'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill); end
        total++; if ({ready_to_transfer, ready_second_buffer, start_second_buffer, overflow, done} !== 5'b0)
            begin bad++; $display("FAIL reset_flags got=%b want=00000",
            {ready_to_transfer, ready_second_buffer, start_second_buffer, overflow, done}); end
        apply(1, 0, 0, 0, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 1, DW'($urandom), 0);
            tick();
        end
        total++; if (fill !== 4'(m_buf.size())) begin bad++; $display("FAIL pre_rst_fill got=%0d want=%0d", fill, m_buf.size()); end
        rst = 1'b1;
        apply(0, 0, 0, 0, 1, 8'hAA, 0);
        tick();
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 8'h00, 0);
        total++; if (state !== 3'd0 || fill !== 4'd0) begin bad++; $display("FAIL mid_rst state=%0d fill=%0d want 0/0", state, fill); end
        total++; if ({ready_to_transfer, ready_second_buffer, start_second_buffer, overflow, done, rd_valid} !== 6'b0)
            begin bad++; $display("FAIL mid_rst_flags got=%b want=000000",
            {ready_to_transfer, ready_second_buffer, start_second_buffer, overflow, done, rd_valid}); end
    endtask

    task automatic test_fill();
        apply(1, 0, 0, 0, 0, 8'h00, 0);
        tick();
        for (int i = 1; i <= DEPTH; i++) begin
            apply(0, 0, 0, 0, 1, DW'(i), 0);
            tick();
            total++; if (fill !== 4'(m_buf.size())) begin bad++; $display("FAIL fill_w%0d got=%0d want=%0d", i, fill, m_buf.size()); end
            total++; if ({ready_to_transfer, ready_second_buffer, start_second_buffer} !== {m_rts, m_rsb, m_ssb})
                begin bad++; $display("FAIL flags_w%0d got=%b want=%b", i,
                {ready_to_transfer, ready_second_buffer, start_second_buffer}, {m_rts, m_rsb, m_ssb}); end
        end
        total++; if (state !== 3'd3) begin bad++; $display("FAIL idle_after_full got=%0d want=3", state); end
        apply(0, 0, 0, 0, 1, 8'hEE, 0);
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow got=%b want=1", overflow); end
        total++; if ({ready_to_transfer, ready_second_buffer, start_second_buffer} !== {m_rts, m_rsb, m_ssb})
            begin bad++; $display("FAIL idle_flags got=%b want=%b",
            {ready_to_transfer, ready_second_buffer, start_second_buffer}, {m_rts, m_rsb, m_ssb}); end
    endtask

    task automatic test_drain();
        int beats = 0;
        int dones = 0;
        apply(0, 0, 1, 0, 0, 8'h00, 0);
        tick();
        for (int c = 0; c < 20 && dones == 0; c++) begin
            apply(0, 0, 0, 0, 0, 8'h00, 1);
            total++; if (rd_valid !== exp_valid()) begin bad++; $display("FAIL drain_valid c%0d got=%b want=%b", c, rd_valid, exp_valid()); end
            if (exp_valid()) begin
                total++; if (rd_data !== DW'(beats + 1)) begin bad++; $display("FAIL drain_data c%0d got=%h want=%h", c, rd_data, beats + 1); end
                beats++;
            end
            tick();
            total++; if (done !== m_done) begin bad++; $display("FAIL drain_done c%0d got=%b want=%b", c, done, m_done); end
            if (done) dones++;
        end
        total++; if (beats != DEPTH || dones != 1) begin bad++; $display("FAIL drain_count beats=%0d dones=%0d want %0d/1", beats, dones, DEPTH); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL drain_end_state got=%0d want=0", state); end
    endtask

    task automatic test_stall();
        int beats = 0;
        int dones = 0;
        logic [DW-1:0] prev;
        bit stalled = 0;
        logic [DW-1:0] last_beat = '0;
        apply(0, 0, 0, 0, 0, 8'h00, 0);
        tick();
        apply(1, 0, 0, 0, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 1, DW'($urandom), 0);
            tick();
        end
        apply(0, 0, 1, 0, 1, 8'h55, 0);
        tick();
        total++; if (state !== 3'd5 || fill !== 4'd5) begin bad++; $display("FAIL stall_entry state=%0d fill=%0d want 5/5", state, fill); end
        for (int c = 0; c < 30 && dones == 0; c++) begin
            apply(0, 0, 0, 0, 1, 8'h99, (c % 2) == 0);
            total++; if (rd_valid !== exp_valid()) begin bad++; $display("FAIL stall_valid c%0d got=%b want=%b", c, rd_valid, exp_valid()); end
            if (exp_valid()) begin
                total++; if (rd_data !== m_buf[m_rd]) begin bad++; $display("FAIL stall_data c%0d got=%h want=%h", c, rd_data, m_buf[m_rd]); end
                if (stalled) begin
                    total++; if (rd_data !== prev) begin bad++; $display("FAIL stall_hold c%0d got=%h want=%h", c, rd_data, prev); end
                end
                prev = rd_data;
                stalled = !rd_ready;
                if (rd_ready) begin beats++; last_beat = rd_data; end
            end
            tick();
            if (done) dones++;
        end
        total++; if (beats != 5 || dones != 1) begin bad++; $display("FAIL stall_count beats=%0d dones=%0d want 5/1", beats, dones); end
        total++; if (last_beat !== 8'h55) begin bad++; $display("FAIL stall_last got=%h want=55", last_beat); end
    endtask

    task automatic test_flush();
        int cnt = 0;
        apply(0, 0, 0, 0, 0, 8'h00, 0);
        tick();
        apply(1, 0, 0, 0, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 0, 0, 0, 1, DW'($urandom), 0);
            tick();
        end
        apply(0, 0, 0, 1, 0, 8'h00, 0);
        tick();
        for (int c = 0; c < 20 && state == 3'd4; c++) begin
            cnt++;
            apply(1, 0, 1, 1, 1, 8'h77, 1);
            tick();
            total++; if (fill !== 4'(m_buf.size())) begin bad++; $display("FAIL flush_fill c%0d got=%0d want=%0d", c, fill, m_buf.size()); end
        end
        total++; if (cnt != DEPTH || state !== 3'd0) begin bad++; $display("FAIL flush_len cycles=%0d state=%0d want %0d/0", cnt, state, DEPTH); end
        apply(1, 0, 0, 0, 0, 8'h00, 0);
        tick();
        apply(0, 0, 1, 0, 0, 8'h00, 0);
        tick();
        apply(0, 0, 0, 0, 0, 8'h00, 1);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b want=0", rd_valid); end
        tick();
        total++; if (done !== 1'b1 || state !== 3'd0) begin bad++; $display("FAIL empty_done done=%b state=%0d want 1/0", done, state); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            apply(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 12) == 0,
                  ($urandom % 4) == 0, ($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0);
            total++; if (rd_valid !== exp_valid()) begin bad++; $display("FAIL rnd_valid c%0d got=%b want=%b", c, rd_valid, exp_valid()); end
            if (exp_valid()) begin
                total++; if (rd_data !== m_buf[m_rd]) begin bad++; $display("FAIL rnd_data c%0d got=%h want=%h", c, rd_data, m_buf[m_rd]); end
            end
            tick();
            total++;
            if (state !== 3'(m_state) || fill !== 4'(m_buf.size()) ||
                {ready_to_transfer, ready_second_buffer, start_second_buffer, overflow, done} !==
                {m_rts, m_rsb, m_ssb, m_ovf, m_done}) begin
                bad++;
                $display("FAIL rnd_regs c%0d state=%0d/%0d fill=%0d/%0d flags=%b/%b", c, state, m_state,
                         fill, m_buf.size(),
                         {ready_to_transfer, ready_second_buffer, start_second_buffer, overflow, done},
                         {m_rts, m_rsb, m_ssb, m_ovf, m_done});
            end
`ifdef SCAN_CKSUM_EN
            total++; if (cksum !== m_ck) begin bad++; $display("FAIL rnd_cksum c%0d got=%h want=%h", c, cksum, m_ck); end
`endif
        end
    endtask

`ifdef SCAN_CKSUM_EN
    task automatic test_cksum();
        logic [DW-1:0] words [3];
        words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'h3C;
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 8'h00, 0);
        tick();
        rst = 1'b0;
        apply(1, 0, 0, 0, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 1, words[i], 0);
            tick();
        end
        total++; if (cksum !== 8'hC3) begin bad++; $display("FAIL cksum_val got=%h want=c3", cksum); end
        apply(0, 0, 1, 0, 0, 8'h00, 1);
        tick();
        for (int c = 0; c < 10 && state != 3'd0; c++) begin
            apply(0, 0, 0, 0, 0, 8'h00, 1);
            tick();
        end
        apply(0, 0, 0, 0, 0, 8'h00, 0);
        tick();
        total++; if (cksum !== 8'h00) begin bad++; $display("FAIL cksum_clear got=%h want=00", cksum); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 8'h00, 0);
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_stall();
        test_flush();
        test_random();
`ifdef SCAN_CKSUM_EN
        test_cksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
